digit_motion_scheduler: RTL

- Sequences the horizontally moving digit on the 96x64 OLED.
- Generates its own step tick and runs a ping-pong traverse of the digit's top-left corner: right, dwell, left, dwell.
- Counts completed loops and advances the displayed digit after each loop.
- Its outputs drive draw_digit's base_x/base_y/value/set inputs, which replaces free-running oscillation with start/stop/loop control.

---
 rtl/digit_motion_scheduler.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/digit_motion_scheduler.sv
// digit_motion_scheduler
// Drives the moving digit on the 96x64 OLED. An internal prescaler makes a
// motion tick. The digit's top-left corner moves right, dwells, moves left
// and dwells again; each round trip is one loop. After every loop the
// displayed digit advances by one, modulo 10.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   en           motion enable; low freezes motion, start/stop still act
//   start        one-cycle run request (IDLE only)
//   stop         one-cycle abort request
//   value_in     initial digit, latched on start (10-15 latch as 0)
//   loops        loops to run, 0 = run until stop
//   base_x       digit left x coordinate, 0..X_MAX
//   base_y       digit top y coordinate, constant BASE_Y
//   digit_value  digit to draw, 0-9
//   digit_set    draw enable, same as busy
//   busy         high when not IDLE
//   done         one-cycle pulse when the programmed loop count completes
//   state        current state encoding, for debug
module digit_motion_scheduler #(
  parameter int OLED_WIDTH  = 96,
  parameter int DIGIT_WIDTH = 16,
  parameter int TICK_DIV    = 1800000,
  parameter int DWELL_TICKS = 8,
  parameter int BASE_Y      = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] value_in,
  input  logic [3:0] loops,
  output logic [6:0] base_x,
  output logic [6:0] base_y,
  output logic [3:0] digit_value,
  output logic       digit_set,
  output logic       busy,
  output logic       done,
  output logic [2:0] state
);

  localparam logic [6:0] X_MAX = 7'(OLED_WIDTH - DIGIT_WIDTH);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS + 1) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'((DWELL_TICKS > 0) ? DWELL_TICKS - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RIGHT   = 3'd1,
    S_DWELL_R = 3'd2,
    S_LEFT    = 3'd3,
    S_DWELL_L = 3'd4
  } state_t;

  state_t        state_reg, state_next;
  logic [6:0]    base_x_reg, base_x_next;
  logic [3:0]    digit_reg, digit_next;
  logic [3:0]    loops_reg, loops_next;
  logic [3:0]    loop_cnt_reg, loop_cnt_next;
  logic [DW-1:0] dwell_reg, dwell_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic          done_reg, done_next;
  logic          busy_int;
  logic          tick;
  logic          end_loop;

  assign busy_int = (state_reg != S_IDLE);
  assign tick     = busy_int && en && (presc_reg == PRESC_LAST);

  always_comb begin
    state_next    = state_reg;
    base_x_next   = base_x_reg;
    digit_next    = digit_reg;
    loops_next    = loops_reg;
    loop_cnt_next = loop_cnt_reg;
    dwell_next    = dwell_reg;
    presc_next    = presc_reg;
    done_next     = 1'b0;
    end_loop      = 1'b0;

    if (busy_int && en)
      presc_next = tick ? '0 : presc_reg + 1'b1;

    case (state_reg)
      S_IDLE: begin
        if (start && !stop) begin
          digit_next    = (value_in > 4'd9) ? 4'd0 : value_in;
          loops_next    = loops;
          base_x_next   = 7'd0;
          loop_cnt_next = 4'd0;
          presc_next    = '0;
          state_next    = S_RIGHT;
        end
      end
      S_RIGHT: begin
        if (tick) begin
          base_x_next = base_x_reg + 7'd1;
          if (base_x_reg + 7'd1 == X_MAX) begin
            dwell_next = '0;
            state_next = (DWELL_TICKS == 0) ? S_LEFT : S_DWELL_R;
          end
        end
      end
      S_DWELL_R: begin
        if (tick) begin
          if (dwell_reg == DWELL_LAST) state_next = S_LEFT;
          else                         dwell_next = dwell_reg + 1'b1;
        end
      end
      S_LEFT: begin
        if (tick) begin
          base_x_next = base_x_reg - 7'd1;
          if (base_x_reg == 7'd1) begin
            dwell_next = '0;
            if (DWELL_TICKS == 0) end_loop   = 1'b1;
            else                  state_next = S_DWELL_L;
          end
        end
      end
      S_DWELL_L: begin
        if (tick) begin
          if (dwell_reg == DWELL_LAST) end_loop   = 1'b1;
          else                         dwell_next = dwell_reg + 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase

    if (end_loop) begin
      loop_cnt_next = loop_cnt_reg + 4'd1;
      digit_next    = (digit_reg == 4'd9) ? 4'd0 : digit_reg + 4'd1;
      if (loops_reg != 4'd0 && (loop_cnt_reg + 4'd1) == loops_reg) begin
        state_next = S_IDLE;
        done_next  = 1'b1;
      end else begin
        state_next = S_RIGHT;
      end
    end

    // An abort overrides any tick in the same cycle: position and digit
    // freeze where they were and no completion is reported.
    if (busy_int && stop) begin
      state_next    = S_IDLE;
      base_x_next   = base_x_reg;
      digit_next    = digit_reg;
      loop_cnt_next = loop_cnt_reg;
      done_next     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      base_x_reg   <= 7'd0;
      digit_reg    <= 4'd0;
      loops_reg    <= 4'd0;
      loop_cnt_reg <= 4'd0;
      dwell_reg    <= '0;
      presc_reg    <= '0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      base_x_reg   <= base_x_next;
      digit_reg    <= digit_next;
      loops_reg    <= loops_next;
      loop_cnt_reg <= loop_cnt_next;
      dwell_reg    <= dwell_next;
      presc_reg    <= presc_next;
      done_reg     <= done_next;
    end
  end

  assign base_x      = base_x_reg;
  assign base_y      = 7'(BASE_Y);
  assign digit_value = digit_reg;
  assign busy        = busy_int;
  assign digit_set   = busy_int;
  assign done        = done_reg;
  assign state       = state_reg;

endmodule
